// File: rtl/alu_sequencer.sv
// Command-level sequencer for the shared n-bit ALU: single-cycle ops pass straight through,
// MUL is run as n shift-add iterations on the ALU adder.
module alu_sequencer #(
  parameter int unsigned n = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [n-1:0] dataa,
  input  logic [n-1:0] datab,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [n-1:0] result,
  output logic [n-1:0] alua,
  output logic [n-1:0] alub,
  output logic [1:0]   aluopout,
  input  logic [n-1:0] alug
);

  localparam int unsigned CntW = $clog2(n + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(n);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      opr_q;
  logic [n-1:0]    ar_q, br_q;
  logic [n-1:0]    acc_q, m_q, q_q;
  logic [CntW-1:0] cnt_q;
  logic [n-1:0]    result_q;
  logic            err_q;

  logic accepting, accept, op_single, op_mul, mul_last;

  assign accepting = (state_q == StIdle) || (state_q == StDone);
  assign accept    = accepting && start;
  assign op_single = (op <= 3'd3);
  assign op_mul    = (op == 3'd4);
  assign mul_last  = (state_q == StMul) && (cnt_q == CntLast);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (op_single)   state_d = StExec;
          else if (op_mul) state_d = StMul;
          else             state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StExec: state_d = StDone;
      StMul:  state_d = (cnt_q == CntLast) ? StDone : StMul;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    alua     = '0;
    alub     = '0;
    aluopout = 2'd0;
    unique case (state_q)
      StExec: begin
        busy     = 1'b1;
        alua     = ar_q;
        alub     = br_q;
        aluopout = opr_q;
      end
      StMul: begin
        busy = 1'b1;
        alua = acc_q;
        alub = q_q[0] ? m_q : '0;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  // Operand latches and multiply iteration registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      opr_q <= 2'd0;
      ar_q  <= '0;
      br_q  <= '0;
      acc_q <= '0;
      m_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      opr_q <= op[1:0];
      ar_q  <= dataa;
      br_q  <= datab;
      if (op_mul) begin
        acc_q <= '0;
        m_q   <= dataa;
        q_q   <= datab;
        cnt_q <= CntInit;
      end
    end else if (state_q == StMul) begin
      acc_q <= alug;
      m_q   <= m_q << 1;
      q_q   <= q_q >> 1;
      cnt_q <= cnt_q - CntLast;
    end
  end

  // Result/err only move on the edge that enters DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept && !op_single && !op_mul) begin
      result_q <= '0;
      err_q    <= 1'b1;
    end else if ((state_q == StExec) || mul_last) begin
      result_q <= alug;
      err_q    <= 1'b0;
    end
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU model on the ALU ports.
module tb_alu_sequencer;

  localparam int unsigned N = 4;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] dataa, datab;
  logic         busy, done, err;
  logic [N-1:0] result, alua, alub, alug;
  logic [1:0]   aluopout;

  int n_cmp = 0;
  int n_err = 0;

  alu_sequencer #(.n(N)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .dataa    (dataa),
    .datab    (datab),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .alua     (alua),
    .alub     (alub),
    .aluopout (aluopout),
    .alug     (alug)
  );

  always #5 clock = ~clock;

  // Shared ALU: 0 ADD, 1 SUB, 2 AND, 3 NOT A.
  always_comb begin
    case (aluopout)
      2'd0:    alug = alua + alub;
      2'd1:    alug = alua - alub;
      2'd2:    alug = alua & alub;
      default: alug = ~alua;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_single(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] res, input string tag);
    op = o; dataa = a; datab = b; start = 1'b1;
    tick();
    start = 1'b0; dataa = ~a; datab = ~b;
    chk({tag, " exec busy"}, busy, 1);
    chk({tag, " exec done"}, done, 0);
    chk({tag, " exec alua"}, alua, a);
    chk({tag, " exec alub"}, alub, b);
    chk({tag, " exec aluop"}, aluopout, o[1:0]);
    tick();
    chk({tag, " done"}, done, 1);
    chk({tag, " done busy"}, busy, 0);
    chk({tag, " result"}, result, res);
    chk({tag, " err"}, err, 0);
    tick();
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle drives"}, {alua, alub, aluopout}, 0);
    chk({tag, " idle hold"}, result, res);
  endtask

  // exp_b packs the expected ALUB per MUL cycle, first cycle in the top nibble.
  task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input logic [3:0] res,
                        input logic [15:0] exp_b, input bit pulse, input string tag);
    op = 3'd4; dataa = a; datab = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s mul%0d busy", tag, i), busy, 1);
      chk($sformatf("%s mul%0d done", tag, i), done, 0);
      chk($sformatf("%s mul%0d alub", tag, i), alub, exp_b[15-4*i -: 4]);
      chk($sformatf("%s mul%0d aluop", tag, i), aluopout, 0);
      if (pulse && i == 1) begin
        op = 3'd0; dataa = 4'd1; datab = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " result"}, result, res);
    chk({tag, " err"}, err, 0);
    tick();
    chk({tag, " idle"}, {busy, done}, 0);
  endtask

  initial begin
    resetn = 1'b1; start = 1'b0; op = 3'd0; dataa = '0; datab = '0;
    #1 resetn = 1'b0;
    #2;
    chk("reset busy/done/err", {busy, done, err}, 0);
    chk("reset result", result, 0);
    chk("reset drives", {alua, alub, aluopout}, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("idle drives", {alua, alub, aluopout}, 0);

    do_single(3'd0, 4'd7, 4'd9, 4'd0, "add 7+9");
    do_single(3'd1, 4'd3, 4'd5, 4'd14, "sub 3-5");
    do_single(3'd2, 4'b1100, 4'b1010, 4'b1000, "and");
    do_single(3'd3, 4'b0101, 4'd0, 4'b1010, "not");

    do_mul(4'd3, 4'd5, 4'd15, {4'd3, 4'd0, 4'd12, 4'd0}, 1'b0, "mul 3x5");
    do_mul(4'd6, 4'd7, 4'd10, {4'd6, 4'd12, 4'd8, 4'd0}, 1'b0, "mul 6x7");
    do_mul(4'hF, 4'd0, 4'd0, 16'h0000, 1'b0, "mul Fx0");
    do_mul(4'd3, 4'd5, 4'd15, {4'd3, 4'd0, 4'd12, 4'd0}, 1'b1, "mul ignore start");

    // Back-to-back: start held through DONE.
    op = 3'd0; dataa = 4'd2; datab = 4'd3; start = 1'b1;
    tick();
    op = 3'd1; dataa = 4'd9; datab = 4'd2;
    tick();
    chk("b2b first done", done, 1);
    chk("b2b first result", result, 5);
    tick();
    start = 1'b0;
    chk("b2b second exec busy", busy, 1);
    chk("b2b second aluop", aluopout, 1);
    tick();
    chk("b2b second done", done, 1);
    chk("b2b second result", result, 7);
    tick();

    // Illegal opcode.
    op = 3'd6; dataa = 4'd3; datab = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal done", done, 1);
    chk("illegal busy", busy, 0);
    chk("illegal err", err, 1);
    chk("illegal result", result, 0);
    tick();
    chk("illegal idle", {busy, done}, 0);
    do_single(3'd0, 4'd1, 4'd2, 4'd3, "add clears err");

    // Reset during the second MUL cycle.
    op = 3'd4; dataa = 4'd3; datab = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre-reset busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("abort outputs", {busy, done, err}, 0);
    chk("abort result", result, 0);
    chk("abort drives", {alua, alub, aluopout}, 0);
    tick();
    tick();
    chk("abort no done", done, 0);
    resetn = 1'b1;
    tick();
    chk("post-reset idle", {busy, done}, 0);
    do_single(3'd0, 4'd1, 4'd1, 4'd2, "add 1+1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
